// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding.
package fifo_burst_reader_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer that absorbs the FIFO's registered read latency.
module fifo_out_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (enq) begin
        mem[tail] <= enq_data;
        tail      <= ~tail;
      end
      if (deq) head <= ~head;
      case ({enq, deq})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // head only moves on an accept, so a stalled word stays put
  assign head_data = mem[head];
endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read engine: pops N+1 words from synch_fifo and streams them out with m_last.
//   state | meaning
//   IDLE  | waiting for a burst request
//   READ  | issuing pops until every word of the burst has been requested
//   DRAIN | all pops done, delivering the words still in the buffer
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  fifo_r_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);
  localparam logic [LEN_WIDTH:0] ONE = (LEN_WIDTH+1)'(1);

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH:0]   pop_left;
  logic [LEN_WIDTH:0]   out_left;
  logic                 inflight;
  logic                 accept;
  logic                 deq;
  logic [1:0]           occ;
  logic [2:0]           room_sum;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign deq       = m_valid && m_ready;

  // buffer slots already claimed next cycle, counting the word still in flight
  assign room_sum  = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_r_en = (state == READ) && (pop_left != '0) && !fifo_empty && (room_sum < 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (out_left == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = READ;
      READ: begin
        if ((pop_left == '0) && !inflight) begin
          if (deq && (out_left == ONE)) state_nxt = IDLE;
          else                          state_nxt = DRAIN;
        end
      end
      DRAIN: if (deq && (out_left == ONE)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_left <= '0;
      out_left <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      if (accept) begin
        pop_left <= {1'b0, req_len} + ONE;
        out_left <= {1'b0, req_len} + ONE;
      end else begin
        if (fifo_r_en) pop_left <= pop_left - ONE;
        if (deq)       out_left <= out_left - ONE;
      end
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (inflight),
    .enq_data  (fifo_data),
    .deq       (deq),
    .occ       (occ),
    .head_data (m_data)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a behavioural synch_fifo model.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LW-1:0] req_len = '0;
  logic          fifo_r_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .fifo_r_en(fifo_r_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  // synch_fifo model: registered read data, registered empty flag
  logic [DW-1:0] fq[$];
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  int            bad_pops = 0;
  int            pops = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_r_en) begin
        if (fq.size() == 0) bad_pops++;
        else begin
          fifo_data <= fq.pop_front();
          pops++;
        end
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // reference: every word written leaves the reader in write order
  logic [DW-1:0] ref_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int len;
    int exp_lat;
    int exp_beats;
    int exp_dur;
  } vec_t;
  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    ref_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic request(input int len);
    int w = 0;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_len   = LW'(len);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic collect(input int len, input int ready_pct, input int wr_pct,
                         output int lat, output int dur);
    int            beats = 0;
    int            cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp;
    lat = -1;
    while (beats <= len && cyc < 4000) begin
      if (prev_stall) check("stable_data", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
      m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      if (wr_pct > 0 && int'($urandom_range(0, 99)) < wr_pct) begin
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        ref_q.push_back(wr_data);
      end else wr_en = 1'b0;
      if (m_valid && lat < 0) lat = cyc;
      if (m_valid) check("m_last", 32'(m_last), 32'(beats == len));
      if (m_valid && m_ready) begin
        exp = (ref_q.size() != 0) ? ref_q.pop_front() : ~m_data;
        check("m_data", 32'(m_data), 32'(exp));
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    check("beats", beats, len + 1);
    check("busy_after", 32'(busy), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    dur = cyc;
  endtask

  initial begin
    int lat, dur, p0, beats;
    int bcyc[2];
    logic [DW-1:0] exp;

    vecs[0] = '{0,   2, 1,   3};
    vecs[1] = '{3,   2, 4,   6};
    vecs[2] = '{7,   2, 8,   10};
    vecs[3] = '{255, 2, 256, 258};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // full-rate bursts from a preloaded FIFO
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i <= vecs[v].len; i++) push_word(DW'($urandom));
      request(vecs[v].len);
      collect(vecs[v].len, 100, 0, lat, dur);
      check("first_latency", lat, vecs[v].exp_lat);
      check("burst_duration", dur, vecs[v].exp_dur);
    end

    // stalled consumer: only two pops fit in the buffer
    for (int i = 0; i < 4; i++) push_word(DW'(8'hA0 + i));
    m_ready = 1'b0;
    p0 = pops;
    request(3);
    repeat (5) tick();
    check("stall_pops", pops - p0, 2);
    check("stall_r_en", 32'(fifo_r_en), 32'd0);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_data", 32'(m_data), 32'hA0);
    collect(3, 100, 0, lat, dur);

    // empty FIFO: words trickle in mid-burst
    m_ready = 1'b1;
    request(1);
    beats = 0;
    bcyc[0] = -1;
    bcyc[1] = -1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b0;
      if (i == 3 || i == 8) begin
        wr_en   = 1'b1;
        wr_data = (i == 3) ? 8'hB0 : 8'hB1;
        ref_q.push_back(wr_data);
      end
      if (m_valid && m_ready) begin
        exp = (ref_q.size() != 0) ? ref_q.pop_front() : ~m_data;
        check("gap_data", 32'(m_data), 32'(exp));
        check("gap_last", 32'(m_last), 32'(beats == 1));
        if (beats < 2) bcyc[beats] = i;
        beats++;
      end
      tick();
    end
    wr_en = 1'b0;
    check("gap_beats", beats, 2);
    check("gap_beat0_cycle", bcyc[0], 6);
    check("gap_beat1_cycle", bcyc[1], 11);
    check("gap_busy", 32'(busy), 32'd0);
    check("gap_bad_pops", bad_pops, 0);

    // single-word bursts back to back
    push_word(8'hC0);
    push_word(8'hC1);
    request(0);
    collect(0, 100, 0, lat, dur);
    check("b2b_ready", 32'(req_ready), 32'd1);
    request(0);
    collect(0, 100, 0, lat, dur);

    // asynchronous reset after two of four words
    for (int i = 0; i < 4; i++) push_word(DW'(8'hD0 + i));
    m_ready = 1'b1;
    request(3);
    beats = 0;
    for (int i = 0; i < 20 && beats < 2; i++) begin
      if (m_valid && m_ready) begin
        exp = (ref_q.size() != 0) ? ref_q.pop_front() : ~m_data;
        check("rst_burst_data", 32'(m_data), 32'(exp));
        beats++;
      end
      tick();
    end
    check("rst_burst_beats", beats, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_r_en", 32'(fifo_r_en), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    ref_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_word(8'hE0);
    push_word(8'hE1);
    request(1);
    collect(1, 100, 0, lat, dur);

    // randomized bursts with random writes and back-pressure
    for (int b = 0; b < 1000; b++) begin
      request(int'($urandom_range(0, 15)));
      collect(int'(req_len), 60, 50, lat, dur);
    end
    check("final_fifo_level", fq.size(), ref_q.size());
    check("never_pop_empty", bad_pops, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
